// File: rtl/robot_pkg.sv
// Shared definitions for the telemetry/alarm frame scheduler: source ids,
// frame constants, default payload lengths and FSM encodings.
package robot_pkg;

    // Source ids double as the id byte of a frame and as the pending bit index.
    localparam logic [1:0] SRC_ALARM = 2'd0;
    localparam logic [1:0] SRC_ECHO  = 2'd1;
    localparam logic [1:0] SRC_TELEM = 2'd2;

    localparam logic [7:0]  HDR_BYTE_DEF  = 8'hAA;
    localparam int unsigned LEN_ALARM_DEF = 3;
    localparam int unsigned LEN_ECHO_DEF  = 1;
    localparam int unsigned LEN_TELEM_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARB   = 3'd1,
        ST_FETCH = 3'd2,
        ST_SEND  = 3'd3,
        ST_WAIT  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Which byte of the frame is currently on the wire.
    typedef enum logic [2:0] {
        PH_HDR  = 3'd0,
        PH_ID   = 3'd1,
        PH_LEN  = 3'd2,
        PH_PAY  = 3'd3,
        PH_CSUM = 3'd4
    } phase_t;

    function automatic logic [2:0] src_onehot(input logic [1:0] id);
        return 3'b001 << id;
    endfunction

endpackage

// File: rtl/req_latch.sv
// Request latch and fixed-priority encoder (alarm > echo > telemetry).
// A request for the source currently being served is parked in rearm so the
// end-of-frame clear cannot swallow it; it re-arms pending when the frame ends.
module req_latch
    import robot_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic [2:0] svc,
    input  logic [2:0] clr,
    output logic [2:0] pending,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    logic [2:0] rearm;

    // Set on request, clear on end/abort of the served frame; set wins over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 3'b000;
            rearm   <= 3'b000;
        end else begin
            pending <= (pending & ~clr) | req | (rearm & clr);
            rearm   <= (rearm | (req & svc)) & ~clr;
        end
    end

    // Fixed-priority pick of the next source to serve.
    always_comb begin
        gnt_valid = |pending;
        gnt_id    = SRC_ALARM;
        if (pending[0]) begin
            gnt_id = SRC_ALARM;
        end else if (pending[1]) begin
            gnt_id = SRC_ECHO;
        end else if (pending[2]) begin
            gnt_id = SRC_TELEM;
        end
    end

endmodule

// File: rtl/tx_frame_sched.sv
// UART frame scheduler: arbitrates three request sources and emits frames
// HDR, id, len, payload[0..len-1], checksum one byte at a time.
// Handshake: tx_start is a one-cycle strobe with tx_data valid; tx_data then
// holds until the UART answers with a one-cycle tx_done, which is only
// honoured in WAIT. rd_data is a combinational function of rd_src/rd_idx.
module tx_frame_sched
    import robot_pkg::*;
#(
    parameter logic [7:0]  HDR_BYTE    = HDR_BYTE_DEF,
    parameter int unsigned LEN_ALARM   = LEN_ALARM_DEF,
    parameter int unsigned LEN_ECHO    = LEN_ECHO_DEF,
    parameter int unsigned LEN_TELEM   = LEN_TELEM_DEF,
    parameter int unsigned TIMEOUT_CYC = 2_500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  req,
    output logic [1:0]  rd_src,
    output logic [3:0]  rd_idx,
    input  logic [7:0]  rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_done,
    output logic        busy,
    output logic [2:0]  pending,
    output logic [15:0] frame_cnt,
    output logic        err,
    output state_t      state_dbg
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    state_t        state;
    phase_t        phase;
    logic [1:0]    gnt_id;
    logic [4:0]    gnt_len;
    logic [7:0]    csum;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;
    logic          enc_valid;
    logic [1:0]    enc_id;
    logic [2:0]    svc;
    logic [2:0]    clr;

    function automatic logic [4:0] len_of(input logic [1:0] id);
        case (id)
            SRC_ALARM: len_of = 5'(LEN_ALARM);
            SRC_ECHO:  len_of = 5'(LEN_ECHO);
            default:   len_of = 5'(LEN_TELEM);
        endcase
    endfunction

    assign state_dbg = state;
    assign tmo_hit   = (state == ST_WAIT) && !tx_done &&
                       (tmo_cnt == TW'(TIMEOUT_CYC - 1));

    req_latch u_req_latch (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .svc       (svc),
        .clr       (clr),
        .pending   (pending),
        .gnt_valid (enc_valid),
        .gnt_id    (enc_id)
    );

    // Source in service (for re-request capture) and the end/abort clear strobe.
    always_comb begin
        svc = 3'b000;
        clr = 3'b000;
        case (state)
            ST_ARB:                              svc = src_onehot(enc_id);
            ST_FETCH, ST_SEND, ST_WAIT, ST_DONE: svc = src_onehot(gnt_id);
            default:                             svc = 3'b000;
        endcase
        if (state == ST_DONE || tmo_hit) begin
            clr = src_onehot(gnt_id);
        end
    end

    // Frame FSM with byte sequencing, checksum, timeout and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            phase     <= PH_HDR;
            gnt_id    <= SRC_ALARM;
            gnt_len   <= 5'd0;
            csum      <= 8'd0;
            tmo_cnt   <= '0;
            tx_data   <= 8'd0;
            tx_start  <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= 16'd0;
            err       <= 1'b0;
            rd_src    <= 2'd0;
            rd_idx    <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enc_valid) begin
                        state <= ST_ARB;
                        busy  <= 1'b1;
                    end
                end
                ST_ARB: begin
                    // Header needs no fetch, so it is loaded straight away.
                    gnt_id   <= enc_id;
                    gnt_len  <= len_of(enc_id);
                    rd_src   <= enc_id;
                    rd_idx   <= 4'd0;
                    csum     <= 8'd0;
                    phase    <= PH_HDR;
                    tx_data  <= HDR_BYTE;
                    tx_start <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_FETCH: begin
                    tx_data  <= rd_data;
                    csum     <= csum + rd_data;
                    tx_start <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    tx_start <= 1'b0;
                    tmo_cnt  <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        tmo_cnt <= '0;
                        case (phase)
                            PH_HDR: begin
                                phase    <= PH_ID;
                                tx_data  <= {6'd0, gnt_id};
                                csum     <= csum + {6'd0, gnt_id};
                                tx_start <= 1'b1;
                                state    <= ST_SEND;
                            end
                            PH_ID: begin
                                phase    <= PH_LEN;
                                tx_data  <= {3'd0, gnt_len};
                                csum     <= csum + {3'd0, gnt_len};
                                tx_start <= 1'b1;
                                state    <= ST_SEND;
                            end
                            PH_LEN: begin
                                phase  <= PH_PAY;
                                rd_idx <= 4'd0;
                                state  <= ST_FETCH;
                            end
                            PH_PAY: begin
                                if ({1'b0, rd_idx} == gnt_len - 5'd1) begin
                                    phase    <= PH_CSUM;
                                    tx_data  <= csum;
                                    tx_start <= 1'b1;
                                    state    <= ST_SEND;
                                end else begin
                                    rd_idx <= rd_idx + 4'd1;
                                    state  <= ST_FETCH;
                                end
                            end
                            PH_CSUM: state <= ST_DONE;
                            default: state <= ST_DONE;
                        endcase
                    end else if (tmo_hit) begin
                        // UART went silent: drop the frame, remember it in err.
                        state   <= ST_IDLE;
                        busy    <= 1'b0;
                        err     <= 1'b1;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    frame_cnt <= frame_cnt + 16'd1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_sched.sv
// Self-checking bench for tx_frame_sched: UART responder, payload ROM model,
// byte scoreboard and one task per scenario.
module tb_tx_frame_sched;
    import robot_pkg::*;

    localparam int TMO      = 100;
    localparam int DONE_DLY = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [1:0]  rd_src;
    logic [3:0]  rd_idx;
    logic [7:0]  rd_data;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_done = 1'b0;
    logic        busy;
    logic [2:0]  pending;
    logic [15:0] frame_cnt;
    logic        err;
    state_t      state_dbg;

    int n_checks = 0;
    int n_fail = 0;
    int byte_cnt = 0;
    int exp_frames = 0;
    int done_budget = -1;
    bit stray_en = 1'b0;
    logic [7:0] exp_q[$];

    tx_frame_sched #(
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .rd_src    (rd_src),
        .rd_idx    (rd_idx),
        .rd_data   (rd_data),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_done   (tx_done),
        .busy      (busy),
        .pending   (pending),
        .frame_cnt (frame_cnt),
        .err       (err),
        .state_dbg (state_dbg)
    );

    // Clock / reset
    always #10 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Payload ROM model: alarm 'A'.., echo 'a'.., telemetry 8'h30+idx.
    function automatic logic [7:0] pay_byte(input logic [1:0] src, input logic [3:0] idx);
        case (src)
            2'd0:    pay_byte = 8'h41 + {4'd0, idx};
            2'd1:    pay_byte = 8'h61 + {4'd0, idx};
            default: pay_byte = 8'h30 + {4'd0, idx};
        endcase
    endfunction

    assign rd_data = pay_byte(rd_src, rd_idx);

    function automatic int len_of_src(input int id);
        if (id == 0) return 3;
        if (id == 1) return 1;
        return 16;
    endfunction

    // Push the full expected byte sequence of one frame.
    task automatic push_frame(input int id);
        logic [7:0] sum;
        logic [7:0] b;
        int len;
        len = len_of_src(id);
        sum = 8'(id) + 8'(len);
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'(id));
        exp_q.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            b = pay_byte(2'(id), 4'(i));
            sum = sum + b;
            exp_q.push_back(b);
        end
        exp_q.push_back(sum);
    endtask

    // Scoreboard: every tx_start pops one expected byte.
    initial begin
        logic [7:0] exp_b;
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                byte_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_tx_start: got tx_data=%02h, required no byte", tx_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (tx_data !== exp_b) begin
                        n_fail++;
                        $display("FAIL tx_byte[%0d]: got %02h, required %02h", byte_cnt, tx_data, exp_b);
                    end
                end
                n_checks++;
                if (prev_start) begin
                    n_fail++;
                    $display("FAIL tx_start_width: got 2+ cycles, required 1");
                end
            end
            prev_start = rst_n && tx_start;
        end
    end

    // UART responder: tx_done DONE_DLY cycles after tx_start, optional stray pulses.
    initial begin
        int cnt;
        bit active;
        logic [7:0] held;
        cnt = 0;
        active = 1'b0;
        held = 8'h00;
        forever begin
            @(negedge clk);
            tx_done = 1'b0;
            if (!rst_n) begin
                active = 1'b0;
            end else if (active) begin
                if (cnt <= 1) begin
                    n_checks++;
                    if (tx_data !== held) begin
                        n_fail++;
                        $display("FAIL tx_data_hold: got %02h, required %02h", tx_data, held);
                    end
                    tx_done = 1'b1;
                    active = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (tx_start) begin
                held = tx_data;
                cnt = DONE_DLY - 1;
                if (done_budget != 0) begin
                    active = 1'b1;
                    if (done_budget > 0) done_budget--;
                end
            end else if (stray_en && (state_dbg == ST_IDLE || state_dbg == ST_FETCH)) begin
                tx_done = 1'b1;
            end
        end
    end

    // Driver tasks
    task automatic pulse(input logic [2:0] r);
        req = r;
        @(negedge clk);
        req = 3'b000;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && pending == 3'b000) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_state(input state_t st, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (state_dbg == st) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Scenarios
    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy_start: got busy=%b tx_start=%b, required 0 0", busy, tx_start);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state_dbg !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, required %0d", state_dbg, ST_IDLE);
        end
        n_checks++;
        if (pending !== 3'b000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pending_err: got %b %b, required 000 0", pending, err);
        end
        n_checks++;
        if (frame_cnt !== 16'd0 || tx_data !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt_data: got %0d %02h, required 0 00", frame_cnt, tx_data);
        end
        n_checks++;
        if (rd_src !== 2'd0 || rd_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_rd: got src=%0d idx=%0d, required 0 0", rd_src, rd_idx);
        end
    endtask

    task automatic test_telem_frame;
        bit ok;
        int base;
        base = byte_cnt;
        push_frame(2);
        pulse(3'b100);
        n_checks++;
        if (pending !== 3'b100) begin
            n_fail++;
            $display("FAIL telem_pending_set: got %b, required 100", pending);
        end
        wait_idle(1000, ok);
        exp_frames++;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL telem_timeout: got busy=%b queue=%0d, required idle", busy, exp_q.size());
        end
        n_checks++;
        if (byte_cnt - base != 20) begin
            n_fail++;
            $display("FAIL telem_bytes: got %0d, required 20", byte_cnt - base);
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames) || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL telem_cnt: got cnt=%0d pend=%b, required %0d 000", frame_cnt, pending, exp_frames);
        end
    endtask

    task automatic test_priority;
        bit ok;
        int base;
        base = byte_cnt;
        push_frame(0);
        push_frame(1);
        push_frame(2);
        pulse(3'b111);
        n_checks++;
        if (pending !== 3'b111) begin
            n_fail++;
            $display("FAIL prio_pending: got %b, required 111", pending);
        end
        wait_idle(2000, ok);
        exp_frames += 3;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL prio_timeout: got busy=%b queue=%0d, required idle", busy, exp_q.size());
        end
        n_checks++;
        if (byte_cnt - base != 32) begin
            n_fail++;
            $display("FAIL prio_bytes: got %0d, required 32", byte_cnt - base);
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL prio_cnt: got %0d, required %0d", frame_cnt, exp_frames);
        end
    endtask

    task automatic test_rerequest;
        bit ok;
        int base;
        push_frame(2);
        push_frame(2);
        push_frame(2);
        pulse(3'b100);
        wait_state(ST_WAIT, 100, ok);
        pulse(3'b100);
        wait_state(ST_DONE, 1000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rereq_done1: got no DONE, required DONE");
        end
        @(negedge clk);
        wait_state(ST_DONE, 1000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rereq_done2: got no DONE, required DONE");
        end
        // Still inside the DONE cycle of the second frame.
        pulse(3'b100);
        wait_idle(2000, ok);
        exp_frames += 3;
        n_checks++;
        if (!ok || frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL rereq_cnt: got %0d, required %0d", frame_cnt, exp_frames);
        end
        base = byte_cnt;
        repeat (50) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || byte_cnt != base) begin
            n_fail++;
            $display("FAIL rereq_extra: got busy=%b bytes=%0d, required 0 0", busy, byte_cnt - base);
        end
    endtask

    task automatic test_timeout;
        bit ok;
        bit seen;
        int k;
        int base;
        base = byte_cnt;
        done_budget = 1;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h02);
        pulse(3'b100);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (state_dbg == ST_WAIT && byte_cnt == base + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL tmo_second_byte: got %0d bytes, required 2", byte_cnt - base);
        end
        k = 0;
        seen = 1'b0;
        while (k < 300) begin
            @(negedge clk);
            k++;
            if (k == 5) req = 3'b001;
            if (k == 6) req = 3'b000;
            if (err) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen || k != TMO) begin
            n_fail++;
            $display("FAIL tmo_err_cycle: got seen=%b at %0d, required 1 at %0d", seen, k, TMO);
        end
        n_checks++;
        if (busy !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL tmo_abort: got busy=%b cnt=%0d, required 0 %0d", busy, frame_cnt, exp_frames);
        end
        n_checks++;
        if (pending !== 3'b001) begin
            n_fail++;
            $display("FAIL tmo_pending: got %b, required 001", pending);
        end
        done_budget = -1;
        push_frame(0);
        wait_idle(1000, ok);
        exp_frames++;
        n_checks++;
        if (!ok || frame_cnt !== 16'(exp_frames) || err !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_next_frame: got cnt=%0d err=%b, required %0d 1", frame_cnt, err, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame;
        bit ok;
        int base;
        push_frame(2);
        pulse(3'b100);
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (state_dbg == ST_FETCH && rd_idx == 4'd5) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rstmid_reach: got no FETCH of byte 5, required reached");
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0 || tx_start !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_ctrl: got st=%0d busy=%b start=%b, required 0 0 0", state_dbg, busy, tx_start);
        end
        n_checks++;
        if (pending !== 3'b000 || err !== 1'b0 || frame_cnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rstmid_status: got %b %b %0d, required 000 0 0", pending, err, frame_cnt);
        end
        n_checks++;
        if (tx_data !== 8'd0 || rd_src !== 2'd0 || rd_idx !== 4'd0) begin
            n_fail++;
            $display("FAIL rstmid_data: got %02h %0d %0d, required 00 0 0", tx_data, rd_src, rd_idx);
        end
        exp_q.delete();
        exp_frames = 0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base = byte_cnt;
        repeat (100) @(negedge clk);
        n_checks++;
        if (byte_cnt != base || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got %0d bytes busy=%b, required 0 0", byte_cnt - base, busy);
        end
    endtask

    task automatic test_stray_done;
        bit ok;
        int base;
        stray_en = 1'b1;
        repeat (6) @(negedge clk);
        n_checks++;
        if (state_dbg !== ST_IDLE || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_idle: got st=%0d busy=%b, required 0 0", state_dbg, busy);
        end
        base = byte_cnt;
        push_frame(2);
        pulse(3'b100);
        wait_idle(1000, ok);
        exp_frames++;
        n_checks++;
        if (!ok || byte_cnt - base != 20) begin
            n_fail++;
            $display("FAIL stray_bytes: got %0d, required 20", byte_cnt - base);
        end
        n_checks++;
        if (frame_cnt !== 16'(exp_frames) || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL stray_cnt: got %0d %b, required %0d 000", frame_cnt, pending, exp_frames);
        end
        stray_en = 1'b0;
    endtask

    // Main sequence and final report
    initial begin
        test_reset();
        test_telem_frame();
        test_priority();
        test_rerequest();
        test_timeout();
        test_reset_mid_frame();
        test_stray_done();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_bytes: got %0d queued, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_frame_sched.md
TX_FRAME_SCHED -- requirements
Module: tx_frame_sched

Interface
REQ-001 Parameter HDR_BYTE, default 8'hAA, frame start byte.
REQ-002 Parameter LEN_ALARM / LEN_ECHO / LEN_TELEM, defaults 3 / 1 / 16, payload bytes per source (each 1..16).
REQ-003 Parameter TIMEOUT_CYC, default 2_500_000, max clk cycles from tx_start to tx_done.
REQ-004 clk  in  1  system clock, 50 MHz.
REQ-005 rst_n  in  1  reset; asynchronous, active-low.
REQ-006 req  in  3  single-cycle request pulses: bit0 gas alarm, bit1 command echo, bit2 periodic telemetry.
REQ-007 rd_src  out  2  source id of the payload byte being fetched (0 alarm, 1 echo, 2 telemetry).
REQ-008 rd_idx  out  4  payload byte index being fetched.
REQ-009 rd_data  in  8  payload byte from the top-level ASCII mux, combinational function of rd_src/rd_idx.
REQ-010 tx_data  out  8  byte to the UART transmitter.
REQ-011 tx_start  out  1  one-cycle pulse: UART shall send tx_data.
REQ-012 tx_done  in  1  one-cycle pulse from the UART when the byte is sent.
REQ-013 busy  out  1  high while a frame is in progress.
REQ-014 pending  out  3  latched unserved requests, same bit order as req.
REQ-015 frame_cnt  out  16  completed frames, wraps 16'hFFFF -> 0.
REQ-016 err  out  1  sticky timeout flag.

Function
REQ-017 Each req bit set in a cycle shall set its pending bit at the next edge; a set and a clear of the same bit in one cycle shall leave it set.
REQ-018 FSM states: IDLE, ARB, FETCH, SEND, WAIT, DONE.
REQ-019 IDLE -> ARB when pending != 0; ARB grants fixed priority alarm > echo > telemetry and latches the granted id and its length.
REQ-020 Arbitration shall be non-preemptive; requests arriving mid-frame only set pending.
REQ-021 Frame byte order: HDR_BYTE, id (8'h00/01/02), length, payload[0..len-1], checksum.
REQ-022 checksum = sum mod 256 of id, length and all payload bytes (header excluded).
REQ-023 FETCH drives rd_src/rd_idx for the next payload byte; rd_data is captured into tx_data on the FETCH -> SEND edge; non-payload bytes skip FETCH.
REQ-024 SEND asserts tx_start for exactly one cycle with tx_data valid; tx_data shall hold stable until tx_done.
REQ-025 WAIT -> next byte (FETCH or SEND) on tx_done; after the checksum byte WAIT -> DONE.
REQ-026 DONE (one cycle): clear granted pending bit, frame_cnt += 1, -> IDLE; busy low from the next cycle.
REQ-027 tx_done outside WAIT shall be ignored.
REQ-028 If TIMEOUT_CYC cycles elapse in WAIT without tx_done: abort frame, set err, clear the granted pending bit, frame_cnt unchanged, -> IDLE.
REQ-029 Minimum back-to-back gap: one IDLE + one ARB cycle between frames.
REQ-030 busy shall be high in all states except IDLE.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, pending 0, tx_data 0, tx_start 0, busy 0, frame_cnt 0, err 0, rd_src 0, rd_idx 0, timeout counter 0.
REQ-032 Reset mid-frame shall abandon the frame with no further tx_start; no recovery byte is sent.

Structure
REQ-033 Source ids, HDR_BYTE, default lengths and state encoding shall live in shared package robot_pkg.
REQ-034 One sub-module, req_latch (pending set/clear logic plus priority encoder), is natural; FSM, checksum accumulator, byte counter and timeout counter stay in tx_frame_sched.

Verification
REQ-035 req=3'b100 once, rd_data = 8'h30+idx, tx_done 10 cycles after each tx_start -> 20 bytes AA 02 10 30..3F checksum, frame_cnt=1, pending=0.
REQ-036 req=3'b111 in one cycle -> frames in order id 00, 01, 02; three frames total, frame_cnt=3.
REQ-037 req bit2 pulsed during a telemetry frame -> second telemetry frame follows; pulse during same frame's DONE cycle still yields one extra frame.
REQ-038 TIMEOUT_CYC=100, tx_done withheld after 2nd byte -> err=1 at cycle 100 of WAIT, busy low, frame_cnt=0, next pending frame starts normally.
REQ-039 rst_n low during payload byte 5 -> all outputs reset values, no tx_start until a new req.
REQ-040 Stray tx_done pulses in IDLE and FETCH -> no state change, byte sequence identical to REQ-035.
